nids_pkt_scheduler: RTL
=======================

Name: nids_pkt_scheduler

Overview:
- Shares one NIDS inference core (DATA_WIDTH/N_FEATURES feature pipeline with pkt_valid/valid_out) between N_SRC packet-feature sources.
- Round-robin arbitrates the sources and streams the granted source's feature words into a feature register bank.
- Issues a single-cycle valid to the core, waits for its result with a timeout, then returns the result tagged with the source ID.
- Sits between feature producers (test-pattern generator, host loader) and the core.

Parameters:
- DATA_WIDTH, 32, width of one feature word and of each score
- N_FEATURES, 28, feature words per packet
- N_SRC, 2, number of requesting sources (≥2)
- TIMEOUT_CYCLES, 64, maximum cycles to wait for core valid_out
- CNT_W, 16, width of the attack counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- src_req  in  N_SRC  per-source request, level
- src_data  in  N_SRC*DATA_WIDTH  per-source feature word; source i at [i*DATA_WIDTH +: DATA_WIDTH]
- src_valid  in  N_SRC  per-source word valid
- src_ready  out  N_SRC  per-source word accept
- src_grant  out  N_SRC  one-hot grant, registered
- core_features  out  N_FEATURES*DATA_WIDTH  feature bank; word k at [k*DATA_WIDTH +: DATA_WIDTH]
- core_valid  out  1  one-cycle pulse to core pkt_valid
- core_valid_out  in  1  core result valid
- core_attack  in  1  core attack_detected
- core_major  in  DATA_WIDTH  core major_score
- core_minor  in  DATA_WIDTH  core minor_score
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_src  out  $clog2(N_SRC)  source index of the result
- res_attack  out  1  latched attack flag
- res_major  out  DATA_WIDTH  latched major score
- res_minor  out  DATA_WIDTH  latched minor score
- res_timeout  out  1  result produced by timeout
- busy  out  1  state != IDLE
- attack_count  out  CNT_W  saturating count of reported attacks

Behaviour:
- Reset values: all outputs 0; feature bank 0; state IDLE; RR pointer 0; word index 0; timer 0.
- FSM states: IDLE, LOAD, ISSUE, WAIT, REPORT.
- IDLE:
  - If any src_req is set, pick the first requester at or after the RR pointer (cyclic), register src_grant one-hot, record its index, clear word index, go to LOAD.
  - Set the RR pointer to granted index+1, wrapping to 0 after N_SRC-1.
  - No request: stay in IDLE.
- LOAD:
  - src_ready[g]=1 only for the granted source; all other src_ready are 0.
  - Each cycle with src_valid[g]: write src_data word into bank[index], index++.
  - When word N_FEATURES-1 is accepted: go to ISSUE.
  - If src_req[g] deasserts while in LOAD: abort to IDLE, clear grant, no core_valid; the partially written bank is left as is. A word accepted in the same cycle is discarded with the abort.
  - Requests from other sources are ignored until IDLE.
- ISSUE: core_valid=1 for exactly one cycle; bank held stable; clear timer; go to WAIT.
- WAIT:
  - bank held stable.
  - core_valid_out=1: latch core_attack/core_major/core_minor, set res_src=g, res_timeout=0, go to REPORT.
  - Otherwise timer++. When timer reaches TIMEOUT_CYCLES-1 without core_valid_out: res_timeout=1, res_attack=0, scores 0, go to REPORT.
- core_valid_out outside WAIT is ignored.
- REPORT:
  - res_valid=1; result fields held stable until res_ready.
  - On res_valid&&res_ready: clear res_valid and grant, return to IDLE. A new arbitration may occur on the following cycle.
  - If res_attack=1 on that handshake, increment attack_count, saturating at all-ones.
- Latency: grant→core_valid = N_FEATURES cycles with continuous valid, +1 for ISSUE. core_valid_out→res_valid = 1 cycle.
- Reset asserted mid-operation: immediate return to the reset values; no partial result is emitted.

Test Plan:
- Reset, src_req=2'b01, 28 words 0..27 with continuous valid -> src_grant=01; core_valid pulses once 29 cycles after the grant; core_features word k = k; src_ready[1] stays 0 throughout.
- Core returns valid_out 5 cycles after core_valid with attack=1, major=0x2A, minor=0x07; res_ready=1 -> res_valid for 1 cycle, res_src=0, res_major=0x2A, res_minor=0x07, res_timeout=0, attack_count=1.
- src_req=2'b11 held for three packets -> grant order 0,1,0.
- No core_valid_out after issue -> res_valid exactly TIMEOUT_CYCLES cycles after WAIT entry; res_timeout=1, res_attack=0, attack_count unchanged.
- src_req[0] drops after 10 words -> return to IDLE, no core_valid; the next grant goes to source 1 if it is requesting.
- res_ready held low 20 cycles -> result fields stable, busy=1; force attack_count to all-ones, then report an attack -> count stays all-ones.
- Assert rst_n low during WAIT -> all outputs 0 immediately; no res_valid afterwards.

Source files
------------

// File: rtl/nids_pkt_scheduler.sv
// nids_pkt_scheduler: round-robin front end that lets several feature sources
// share one NIDS inference core. A granted source streams N_FEATURES words into
// a register bank. The core is then pulsed and its result is awaited under a
// timeout. The result is returned tagged with the source index.
module nids_pkt_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int N_FEATURES     = 28,
  parameter int N_SRC          = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_SRC-1:0]                 src_req,
  input  logic [N_SRC*DATA_WIDTH-1:0]      src_data,
  input  logic [N_SRC-1:0]                 src_valid,
  output logic [N_SRC-1:0]                 src_ready,
  output logic [N_SRC-1:0]                 src_grant,
  output logic [N_FEATURES*DATA_WIDTH-1:0] core_features,
  output logic                             core_valid,
  input  logic                             core_valid_out,
  input  logic                             core_attack,
  input  logic [DATA_WIDTH-1:0]            core_major,
  input  logic [DATA_WIDTH-1:0]            core_minor,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [$clog2(N_SRC)-1:0]         res_src,
  output logic                             res_attack,
  output logic [DATA_WIDTH-1:0]            res_major,
  output logic [DATA_WIDTH-1:0]            res_minor,
  output logic                             res_timeout,
  output logic                             busy,
  output logic [CNT_W-1:0]                 attack_count
);

  localparam int IDX_W = $clog2(N_SRC);
  localparam int SUM_W = IDX_W + 1;
  localparam int WI_W  = (N_FEATURES > 1) ? $clog2(N_FEATURES) : 1;
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, REPORT} state_t;

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      grant_idx_reg;
  logic [IDX_W-1:0]      rr_ptr_reg;
  logic [N_SRC-1:0]      grant_reg;
  logic [WI_W-1:0]       word_idx_reg;
  logic [TMR_W-1:0]      timer_reg;
  logic                  core_valid_reg;
  logic                  res_valid_reg;
  logic [IDX_W-1:0]      res_src_reg;
  logic                  res_attack_reg;
  logic [DATA_WIDTH-1:0] res_major_reg;
  logic [DATA_WIDTH-1:0] res_minor_reg;
  logic                  res_timeout_reg;
  logic [CNT_W-1:0]      attack_count_reg;
  logic [DATA_WIDTH-1:0] bank_reg [N_FEATURES];
  logic [DATA_WIDTH-1:0] src_word [N_SRC];

  logic                  arb_found;
  logic [IDX_W-1:0]      arb_idx;
  logic [SUM_W-1:0]      arb_sum;
  logic [N_SRC-1:0]      arb_onehot;
  logic                  cur_req;
  logic                  cur_valid;
  logic                  word_accept;
  logic                  last_word;
  logic                  timer_expired;
  logic                  res_fire;

  // Unpack the flat source data bus and drive the flat feature bus.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src_word
      assign src_word[gi] = src_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
    for (genvar gi = 0; gi < N_FEATURES; gi++) begin : g_feat_out
      assign core_features[gi*DATA_WIDTH +: DATA_WIDTH] = bank_reg[gi];
    end
  endgenerate

  assign cur_req       = src_req[grant_idx_reg];
  assign cur_valid     = src_valid[grant_idx_reg];
  // A word arriving in the same cycle the request drops is discarded.
  assign word_accept   = (state_reg == LOAD) && cur_req && cur_valid;
  assign last_word     = (word_idx_reg == WI_W'(N_FEATURES - 1));
  assign timer_expired = (timer_reg == TMR_W'(TIMEOUT_CYCLES - 1));
  assign res_fire      = (state_reg == REPORT) && res_valid_reg && res_ready;

  // Cyclic priority search: the first requester at or after rr_ptr wins.
  // The loop runs downward so the smallest offset is assigned last.
  always_comb begin
    arb_found  = 1'b0;
    arb_idx    = '0;
    arb_sum    = '0;
    arb_onehot = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      arb_sum = {1'b0, rr_ptr_reg} + SUM_W'(k);
      if (arb_sum >= SUM_W'(N_SRC)) arb_sum = arb_sum - SUM_W'(N_SRC);
      if (src_req[arb_sum[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = arb_sum[IDX_W-1:0];
      end
    end
    arb_onehot[arb_idx] = 1'b1;
  end

  // Next-state logic for the load / issue / wait / report sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (arb_found) state_next = LOAD;
      LOAD: begin
        if (!cur_req)                    state_next = IDLE;
        else if (cur_valid && last_word) state_next = ISSUE;
      end
      ISSUE:  state_next = WAIT;
      WAIT:   if (core_valid_out || timer_expired) state_next = REPORT;
      REPORT: if (res_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Grant, word index, timer, result and attack-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_idx_reg    <= '0;
      rr_ptr_reg       <= '0;
      grant_reg        <= '0;
      word_idx_reg     <= '0;
      timer_reg        <= '0;
      core_valid_reg   <= 1'b0;
      res_valid_reg    <= 1'b0;
      res_src_reg      <= '0;
      res_attack_reg   <= 1'b0;
      res_major_reg    <= '0;
      res_minor_reg    <= '0;
      res_timeout_reg  <= 1'b0;
      attack_count_reg <= '0;
    end else begin
      // Registered so the core sees a glitch-free one-cycle pulse.
      core_valid_reg <= (state_reg == ISSUE);
      case (state_reg)
        IDLE: begin
          if (arb_found) begin
            grant_reg     <= arb_onehot;
            grant_idx_reg <= arb_idx;
            word_idx_reg  <= '0;
            rr_ptr_reg    <= (arb_idx == IDX_W'(N_SRC - 1)) ? '0 : arb_idx + 1'b1;
          end
        end
        LOAD: begin
          if (!cur_req)       grant_reg    <= '0;
          else if (cur_valid) word_idx_reg <= word_idx_reg + 1'b1;
        end
        ISSUE: timer_reg <= '0;
        WAIT: begin
          if (core_valid_out) begin
            res_valid_reg   <= 1'b1;
            res_src_reg     <= grant_idx_reg;
            res_attack_reg  <= core_attack;
            res_major_reg   <= core_major;
            res_minor_reg   <= core_minor;
            res_timeout_reg <= 1'b0;
          end else if (timer_expired) begin
            res_valid_reg   <= 1'b1;
            res_src_reg     <= grant_idx_reg;
            res_attack_reg  <= 1'b0;
            res_major_reg   <= '0;
            res_minor_reg   <= '0;
            res_timeout_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        REPORT: begin
          if (res_fire) begin
            res_valid_reg <= 1'b0;
            grant_reg     <= '0;
            if (res_attack_reg && (attack_count_reg != '1))
              attack_count_reg <= attack_count_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Feature bank: each word captures the granted source's data at its index
  // and is otherwise held, including across an aborted load.
  generate
    for (genvar gi = 0; gi < N_FEATURES; gi++) begin : g_bank
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          bank_reg[gi] <= '0;
        else if (word_accept && (word_idx_reg == WI_W'(gi)))
          bank_reg[gi] <= src_word[grant_idx_reg];
      end
    end
  endgenerate

  assign src_ready    = (state_reg == LOAD) ? grant_reg : '0;
  assign src_grant    = grant_reg;
  assign core_valid   = core_valid_reg;
  assign res_valid    = res_valid_reg;
  assign res_src      = res_src_reg;
  assign res_attack   = res_attack_reg;
  assign res_major    = res_major_reg;
  assign res_minor    = res_minor_reg;
  assign res_timeout  = res_timeout_reg;
  assign busy         = (state_reg != IDLE);
  assign attack_count = attack_count_reg;

endmodule
